// File: rtl/ssfr_sequencer.sv
// rtl/ssfr_sequencer.sv - SSFR writer: reset/config/run/drain/stop layer sequence with shadow copy
module ssfr_sequencer #(
   parameter int RST_HOLD  = 4,
   parameter int DRAIN_CYC = 8,
   parameter int TIMEOUT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [2:0]           sel_out,
   input  logic [3:0]           bypass_relu,
   input  logic [TIMEOUT_W-1:0] timeout,
   input  logic                 conv_done,
   output logic [15:0]          ssfr_data,
   output logic                 ssfr_wr,
   output logic [15:0]          shadow,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam int HOLD_W = 16;
   localparam logic [15:0]       SSFR_RST   = 16'h20A8;
   localparam logic [HOLD_W-1:0] RST_LAST   = HOLD_W'(RST_HOLD - 1);
   localparam logic [HOLD_W-1:0] DRAIN_LAST = HOLD_W'(DRAIN_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RSTA,
      S_CFG,
      S_RUN,
      S_DRAIN,
      S_STOP
   } state_t;

   state_t               state_q, state_d;
   logic [HOLD_W-1:0]    hold_q, hold_d;
   logic [TIMEOUT_W-1:0] wd_q, wd_d;
   logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
   logic [2:0]           sel_q, sel_d;
   logic [3:0]           byp_q, byp_d;
   logic [15:0]          data_q, data_d;
   logic [15:0]          shadow_q, shadow_d;
   logic                 wr_q, wr_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic [8:0]           ctl;
   logic                 expire;

   // Watchdog fires on the cycle the in-RUN count would reach the limit.
   assign expire = (tmo_q != '0) && (wd_q == tmo_q - TIMEOUT_W'(1));

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      wd_d     = wd_q;
      tmo_d    = tmo_q;
      sel_d    = sel_q;
      byp_d    = byp_q;
      data_d   = data_q;
      err_d    = err_q;
      wr_d     = 1'b0;
      done_d   = 1'b0;
      ctl      = '0;
      shadow_d = wr_q ? data_q : shadow_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               sel_d   = sel_out;
               byp_d   = bypass_relu;
               tmo_d   = timeout;
               err_d   = 1'b0;
               state_d = S_RSTA;
            end
         end
         S_RSTA: begin
            if (abort) begin
               err_d   = 1'b1;
               state_d = S_STOP;
            end else if (hold_q == RST_LAST) begin
               state_d = S_CFG;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         S_CFG: begin
            if (abort) begin
               err_d   = 1'b1;
               state_d = S_STOP;
            end else begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (abort) begin
               err_d   = 1'b1;
               state_d = S_STOP;
            end else if (conv_done) begin
               state_d = S_DRAIN;
            end else if (expire) begin
               err_d   = 1'b1;
               state_d = S_STOP;
            end else begin
               wd_d = wd_q + TIMEOUT_W'(1);
            end
         end
         S_DRAIN: begin
            if (abort) begin
               err_d   = 1'b1;
               state_d = S_STOP;
            end else if (hold_q == DRAIN_LAST) begin
               state_d = S_STOP;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         S_STOP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (state_d != state_q) begin
         hold_d = '0;
         wd_d   = '0;
      end

      // One strobe per state, registered so it lands on the state's first cycle.
      if ((state_d != state_q) && (state_d != S_IDLE)) begin
         case (state_d)
            S_RSTA:  ctl = 9'b0_1_0_1_0_1_000;
            S_RUN:   ctl = 9'b1_0_1_0_1_0_000;
            S_DRAIN: ctl = 9'b1_0_1_0_0_0_000;
            default: ctl = 9'b0;
         endcase
         wr_d   = 1'b1;
         data_d = {sel_d, byp_d, ctl};
         done_d = (state_d == S_STOP) && !err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         hold_q   <= '0;
         wd_q     <= '0;
         tmo_q    <= '0;
         sel_q    <= '0;
         byp_q    <= '0;
         data_q   <= SSFR_RST;
         shadow_q <= SSFR_RST;
         wr_q     <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         wd_q     <= wd_d;
         tmo_q    <= tmo_d;
         sel_q    <= sel_d;
         byp_q    <= byp_d;
         data_q   <= data_d;
         shadow_q <= shadow_d;
         wr_q     <= wr_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign ssfr_data = data_q;
   assign ssfr_wr   = wr_q;
   assign shadow    = shadow_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_ssfr_sequencer.sv
// tb/tb_ssfr_sequencer.sv - self-checking bench for ssfr_sequencer
module tb_ssfr_sequencer;

   localparam int RH  = 4;
   localparam int DC  = 8;
   localparam int N   = 2048;
   localparam int BIG = 1000000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [2:0]  sel_out = '0;
   logic [3:0]  bypass_relu = '0;
   logic [15:0] timeout = '0;
   logic        conv_done = 1'b0;
   logic [15:0] ssfr_data;
   logic        ssfr_wr;
   logic [15:0] shadow;
   logic        busy;
   logic        done;
   logic        err;

   always #5 clk = ~clk;

   ssfr_sequencer #(
      .RST_HOLD (RH),
      .DRAIN_CYC(DC),
      .TIMEOUT_W(16)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .abort      (abort),
      .sel_out    (sel_out),
      .bypass_relu(bypass_relu),
      .timeout    (timeout),
      .conv_done  (conv_done),
      .ssfr_data  (ssfr_data),
      .ssfr_wr    (ssfr_wr),
      .shadow     (shadow),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        exp_valid [N];
   logic        exp_wr    [N];
   logic        exp_busy  [N];
   logic        exp_done  [N];
   logic        exp_err   [N];
   logic [15:0] exp_data  [N];
   logic [15:0] exp_sh    [N];

   int n_chk  = 0;
   int n_pass = 0;

   logic [15:0] log_d[$];
   int          log_t[$];
   int          done_seen = 0;

   logic [15:0] m_data = 16'h20A8;
   logic        m_err  = 1'b0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
   endtask

   always @(negedge clk) begin
      if (cyc < N && exp_valid[cyc]) begin
         check("ssfr_wr",   {15'b0, ssfr_wr}, {15'b0, exp_wr[cyc]});
         check("ssfr_data", ssfr_data,        exp_data[cyc]);
         check("shadow",    shadow,           exp_sh[cyc]);
         check("busy",      {15'b0, busy},    {15'b0, exp_busy[cyc]});
         check("done",      {15'b0, done},    {15'b0, exp_done[cyc]});
         check("err",       {15'b0, err},     {15'b0, exp_err[cyc]});
         if (ssfr_wr === 1'b1) begin
            log_d.push_back(ssfr_data);
            log_t.push_back(cyc);
         end
         if (done === 1'b1) done_seen++;
      end
   end

   // st: 0 RSTA, 1 CFG, 2 RUN, 3 DRAIN, 4 STOP
   function automatic logic [15:0] word(input int st, input logic [2:0] sel, input logic [3:0] byp);
      logic rst_all, en_fc, en_conv;
      rst_all = (st == 0);
      en_fc   = (st == 2) || (st == 3);
      en_conv = (st == 2);
      return {sel, byp, en_fc, rst_all, en_fc, rst_all, en_conv, rst_all, 3'b000};
   endfunction

   task automatic fill(input int c, input logic wr, input logic [15:0] d, input logic [15:0] sh,
                       input logic b, input logic dn, input logic e);
      if (c < N) begin
         exp_valid[c] = 1'b1;
         exp_wr[c]    = wr;
         exp_data[c]  = d;
         exp_sh[c]    = sh;
         exp_busy[c]  = b;
         exp_done[c]  = dn;
         exp_err[c]   = e;
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         fill(cyc, 1'b0, m_data, m_data, 1'b0, 1'b0, m_err);
         @(posedge clk); #1;
      end
   endtask

   task automatic clear_log();
      log_d.delete();
      log_t.delete();
      done_seen = 0;
   endtask

   // Event-time model of one sequence started in the current cycle.
   task automatic run(input logic [2:0] sel, input logic [3:0] byp, input logic [15:0] tmo,
                      input int conv_off, input int abort_off, input int extra_start_off, input int rst_off);
      int          s, r, cd, ex, a, rr, stop, endc, n;
      logic        run_err, wr;
      int          st_t[5];
      logic [15:0] st_d[5];
      logic [15:0] cur_d, cur_sh;
      s  = cyc;
      r  = s + RH + 2;
      cd = (conv_off >= 0) ? r + conv_off : BIG;
      ex = (tmo != 0) ? r + int'(tmo) - 1 : BIG;
      a  = (abort_off >= 0) ? s + abort_off : BIG;
      rr = (rst_off >= 0) ? s + rst_off : BIG;
      st_t[0] = s + 1;      st_d[0] = word(0, sel, byp);
      st_t[1] = s + 1 + RH; st_d[1] = word(1, sel, byp);
      st_t[2] = r;          st_d[2] = word(2, sel, byp);
      if (cd <= ex) begin
         st_t[3] = cd + 1; st_d[3] = word(3, sel, byp);
         stop = cd + 1 + DC; run_err = 1'b0; n = 4;
      end else begin
         stop = ex + 1; run_err = 1'b1; n = 3;
      end
      if (a >= s + 1 && a < stop) begin
         stop = a + 1;
         run_err = 1'b1;
         while (n > 0 && st_t[n-1] > a) n--;
      end
      st_t[n] = stop; st_d[n] = word(4, sel, byp); n++;
      endc = (rst_off >= 0) ? rr + 1 : stop + 1;
      cur_d  = m_data;
      cur_sh = m_data;
      for (int c = s; c <= endc; c++) begin
         if (rst_off >= 0 && c == rr + 1) begin
            fill(c, 1'b0, 16'h20A8, 16'h20A8, 1'b0, 1'b0, 1'b0);
         end else begin
            wr = 1'b0;
            for (int i = 0; i < n; i++) if (st_t[i] == c) begin wr = 1'b1; cur_d = st_d[i]; end
            fill(c, wr, cur_d, cur_sh, (c > s && c <= stop), (c == stop && !run_err),
                 (c <= s) ? m_err : ((c >= stop) ? run_err : 1'b0));
            if (wr) cur_sh = cur_d;
         end
      end
      if (rst_off >= 0) begin
         m_data = 16'h20A8;
         m_err  = 1'b0;
      end else begin
         m_data = cur_d;
         m_err  = run_err;
      end
      for (int c = s; c <= endc; c++) begin
         start       = (c == s) || (extra_start_off >= 0 && c == s + extra_start_off);
         abort       = (c == a);
         conv_done   = (c == cd);
         reset_n     = !(c == rr);
         sel_out     = (c == s) ? sel : ~sel;
         bypass_relu = (c == s) ? byp : ~byp;
         timeout     = (c == s) ? tmo : ~tmo;
         @(posedge clk); #1;
      end
      start = 1'b0; abort = 1'b0; conv_done = 1'b0; reset_n = 1'b1;
   endtask

   function automatic logic [15:0] log_at(input int i);
      return (i < log_d.size()) ? log_d[i] : 16'hDEAD;
   endfunction

   function automatic logic [15:0] gap(input int i, input int j);
      return (i < log_t.size() && j < log_t.size()) ? 16'(log_t[j] - log_t[i]) : 16'hDEAD;
   endfunction

   logic [15:0] t2w [5] = '{16'hA6A8, 16'hA600, 16'hA750, 16'hA740, 16'hA600};
   int s0;

   initial begin
      #50000;
      $display("FAIL sim_timeout: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < N; i++) exp_valid[i] = 1'b0;
      @(posedge clk); #1;
      idle(1);
      reset_n = 1'b1;
      idle(3);
      check("t1_shadow", shadow, 16'h20A8);
      check("t1_data", ssfr_data, 16'h20A8);
      check("t1_busy", {15'b0, busy}, 16'h0000);

      clear_log();
      s0 = cyc;
      run(3'b101, 4'b0011, 16'd0, 20, -1, -1, -1);
      idle(2);
      check("t2_count", 16'(log_d.size()), 16'd5);
      for (int i = 0; i < 5; i++) check("t2_word", log_at(i), t2w[i]);
      check("t2_latency", (log_t.size() > 2) ? 16'(log_t[2] - s0) : 16'hDEAD, 16'd6);
      check("t2_done", 16'(done_seen), 16'd1);
      check("t2_busy", {15'b0, busy}, 16'h0000);

      clear_log();
      run(3'b101, 4'b0011, 16'd10, -1, -1, -1, -1);
      idle(2);
      check("t3_count", 16'(log_d.size()), 16'd4);
      check("t3_gap", gap(2, 3), 16'd10);
      check("t3_stop", log_at(3), 16'hA600);
      check("t3_err", {15'b0, err}, 16'h0001);
      check("t3_done", 16'(done_seen), 16'd0);

      run(3'b010, 4'b1100, 16'd50, 5, -1, -1, -1);
      idle(2);
      check("t3_err_clr", {15'b0, err}, 16'h0000);

      clear_log();
      run(3'b101, 4'b0011, 16'd0, 3, RH + 8, 3, -1);
      idle(2);
      check("t4_count", 16'(log_d.size()), 16'd5);
      check("t4_stop", log_at(4), 16'hA600);
      check("t4_gap", gap(3, 4), 16'd3);
      check("t4_err", {15'b0, err}, 16'h0001);
      check("t4_done", 16'(done_seen), 16'd0);

      clear_log();
      run(3'b011, 4'b1010, 16'd7, 6, -1, -1, -1);
      idle(2);
      check("t5_drain", log_at(3), 16'h7540);
      check("t5_err", {15'b0, err}, 16'h0000);
      check("t5_done", 16'(done_seen), 16'd1);

      clear_log();
      run(3'b101, 4'b0011, 16'd0, -1, -1, -1, RH + 7);
      check("t5_rst_shadow", shadow, 16'h20A8);
      check("t5_rst_wr", {15'b0, ssfr_wr}, 16'h0000);
      idle(3);
      check("t5_rst_count", 16'(log_d.size()), 16'd3);

      clear_log();
      run(3'b111, 4'b1111, 16'd0, -1, 2, -1, -1);
      idle(2);
      check("abort_rsta_count", 16'(log_d.size()), 16'd2);
      check("abort_rsta_stop", log_at(1), 16'hFE00);

      clear_log();
      run(3'b000, 4'b0001, 16'd1, -1, -1, -1, -1);
      idle(2);
      check("tmo1_gap", gap(2, 3), 16'd1);
      check("tmo1_err", {15'b0, err}, 16'h0001);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
